// File: rtl/myproject_dense_pkg.sv
// Shared types and helpers for the dense-layer streaming accumulator.
// The sizing functions are evaluated at elaboration time only.
package myproject_dense_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_OUT  = 2'd2
   } state_e;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // The accumulator needs room for the wider operand, growth over n_in terms, and a sign bit.
   function automatic bit acc_width_ok(input int n_in, input int prod_w, input int bias_w,
                                       input int acc_w);
      int widest;
      widest = (prod_w > bias_w) ? prod_w : bias_w;
      return acc_w >= widest + clog2(n_in) + 1;
   endfunction

endpackage

// File: rtl/myproject_dense_acc_quant.sv
// Combinational requantizer: arithmetic right shift, optional ReLU, then
// saturation of the accumulator into the signed output range.
module myproject_dense_acc_quant
   import myproject_dense_pkg::*;
#(
   parameter int ACC_WIDTH = 26,
   parameter int SHIFT     = 4,
   parameter int OUT_WIDTH = 16,
   parameter int RELU      = 1
) (
   input  logic signed [ACC_WIDTH-1:0] acc_i,
   output logic signed [OUT_WIDTH-1:0] q_o
);

   localparam logic signed [ACC_WIDTH-1:0] MAX_V =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] MIN_V =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   logic signed [ACC_WIDTH-1:0] shifted;
   logic signed [ACC_WIDTH-1:0] relu_v;

   always_comb begin
      shifted = acc_i >>> SHIFT;
      relu_v  = shifted;
      if ((RELU != 0) && shifted[ACC_WIDTH-1]) begin
         relu_v = '0;
      end
      if (relu_v > MAX_V) begin
         q_o = MAX_V[OUT_WIDTH-1:0];
      end else if (relu_v < MIN_V) begin
         q_o = MIN_V[OUT_WIDTH-1:0];
      end else begin
         q_o = relu_v[OUT_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/myproject_dense_acc.sv
// Streaming per-neuron accumulator: bias + N_IN products, requantized and
// presented on a registered valid/ready output.
module myproject_dense_acc
   import myproject_dense_pkg::*;
#(
   parameter int N_IN       = 16,
   parameter int PROD_WIDTH = 20,
   parameter int BIAS_WIDTH = 16,
   parameter int ACC_WIDTH  = 26,
   parameter int SHIFT      = 4,
   parameter int OUT_WIDTH  = 16,
   parameter int RELU       = 1
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic [PROD_WIDTH-1:0] prod_tdata,
   input  logic                  prod_tvalid,
   output logic                  prod_tready,
   input  logic [BIAS_WIDTH-1:0] bias,
   output logic [OUT_WIDTH-1:0]  out_tdata,
   output logic                  out_tvalid,
   input  logic                  out_tready
);

   localparam int CNT_W  = clog2(N_IN + 1);
   localparam bit ACC_OK = acc_width_ok(N_IN, PROD_WIDTH, BIAS_WIDTH, ACC_WIDTH);

   if (!ACC_OK) begin : g_acc_width_check
      $error("myproject_dense_acc: ACC_WIDTH too narrow for N_IN/PROD_WIDTH/BIAS_WIDTH");
   end

   state_e                      state_q, state_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [OUT_WIDTH-1:0]        out_data_q, out_data_d;
   logic                        out_valid_q, out_valid_d;
   logic signed [ACC_WIDTH-1:0] prod_ext, bias_ext;
   logic signed [OUT_WIDTH-1:0] quant_q;

   assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_tdata[PROD_WIDTH-1]}}, prod_tdata};
   assign bias_ext = {{(ACC_WIDTH-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias};

   // Quantizes the next-state sum so the result can be latched on the entering edge.
   myproject_dense_acc_quant #(
      .ACC_WIDTH(ACC_WIDTH),
      .SHIFT    (SHIFT),
      .OUT_WIDTH(OUT_WIDTH),
      .RELU     (RELU)
   ) u_quant (
      .acc_i(acc_d),
      .q_o  (quant_q)
   );

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      prod_tready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            prod_tready = 1'b1;
            if (prod_tvalid) begin
               acc_d = bias_ext + prod_ext;
               cnt_d = CNT_W'(1);
               if (N_IN == 1) begin
                  state_d     = ST_OUT;
                  out_valid_d = 1'b1;
                  out_data_d  = quant_q;
               end else begin
                  state_d = ST_ACC;
               end
            end
         end
         ST_ACC: begin
            prod_tready = 1'b1;
            if (prod_tvalid) begin
               acc_d = acc_q + prod_ext;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(N_IN - 1)) begin
                  state_d     = ST_OUT;
                  out_valid_d = 1'b1;
                  out_data_d  = quant_q;
               end
            end
         end
         ST_OUT: begin
            if (out_tready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_tdata  = out_data_q;
   assign out_tvalid = out_valid_q;

endmodule

// File: tb/tb_myproject_dense_acc.sv
// Directed bench for myproject_dense_acc over three parameterizations:
// 0: N_IN=4 SHIFT=0 RELU=0, 1: N_IN=16 SHIFT=4 RELU=0, 2: N_IN=4 SHIFT=0 RELU=1.
module tb_myproject_dense_acc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [19:0] pd  [3];
   logic        pv  [3];
   logic        pr  [3];
   logic [15:0] bs  [3];
   logic [15:0] od  [3];
   logic        ov  [3];
   logic        otr [3];

   int n_cmp = 0;
   int n_err = 0;
   int vec [16];

   always #5 clk = ~clk;

   myproject_dense_acc #(.N_IN(4), .SHIFT(0), .RELU(0)) dut_a (
      .ap_clk(clk), .ap_rst_n(rst_n),
      .prod_tdata(pd[0]), .prod_tvalid(pv[0]), .prod_tready(pr[0]), .bias(bs[0]),
      .out_tdata(od[0]), .out_tvalid(ov[0]), .out_tready(otr[0]));

   myproject_dense_acc #(.N_IN(16), .SHIFT(4), .RELU(0)) dut_b (
      .ap_clk(clk), .ap_rst_n(rst_n),
      .prod_tdata(pd[1]), .prod_tvalid(pv[1]), .prod_tready(pr[1]), .bias(bs[1]),
      .out_tdata(od[1]), .out_tvalid(ov[1]), .out_tready(otr[1]));

   myproject_dense_acc #(.N_IN(4), .SHIFT(0), .RELU(1)) dut_c (
      .ap_clk(clk), .ap_rst_n(rst_n),
      .prod_tdata(pd[2]), .prod_tvalid(pv[2]), .prod_tready(pr[2]), .bias(bs[2]),
      .out_tdata(od[2]), .out_tvalid(ov[2]), .out_tready(otr[2]));

   // Offers one product starting at a negedge and returns at the following negedge.
   task automatic push(input int d, input int v, input bit gap);
      int g;
      g = 0;
      if (gap) begin
         while (g < 4 && $urandom_range(0, 1) == 1) begin
            @(negedge clk);
            g++;
         end
      end
      pd[d] = 20'(v);
      pv[d] = 1'b1;
      @(negedge clk);
      pv[d] = 1'b0;
   endtask

   task automatic collect(input int d, input string name, input int exp);
      int t;
      t = 0;
      while (ov[d] !== 1'b1 && t < 60) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (ov[d] !== 1'b1 || $signed(od[d]) !== exp) begin
         $display("FAIL %s: out_tdata=%0d out_tvalid=%b, required %0d valid", name,
                  $signed(od[d]), ov[d], exp);
         n_err++;
      end else begin
         $display("txn %s: dut%0d out_tdata=%0d", name, d, $signed(od[d]));
      end
      otr[d] = 1'b1;
      @(negedge clk);
      otr[d] = 1'b0;
   endtask

   task automatic run_neuron(input int d, input string name, input int b, input int n,
                             input bit gap, input bit alter_bias, input int exp);
      bs[d] = 16'(b);
      for (int i = 0; i < n; i++) begin
         push(d, vec[i], gap);
         if (alter_bias) bs[d] = 16'($urandom_range(0, 65535));
      end
      collect(d, name, exp);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         pd[d] = '0; pv[d] = 1'b0; bs[d] = '0; otr[d] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         n_cmp++;
         if (pr[d] !== 1'b1 || ov[d] !== 1'b0 || od[d] !== 16'd0) begin
            $display("FAIL reset_dut%0d: ready=%b valid=%b data=%0d, required 1 0 0",
                     d, pr[d], ov[d], od[d]);
            n_err++;
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      bs[0] = 16'd0;
      push(0, 100, 0); push(0, 200, 0); push(0, -50, 0);
      n_cmp++;
      if (ov[0] !== 1'b0) begin
         $display("FAIL b2b_early_valid: out_tvalid=%b, required 0", ov[0]); n_err++;
      end
      push(0, 10, 0);
      n_cmp++;
      if (ov[0] !== 1'b1 || pr[0] !== 1'b0) begin
         $display("FAIL b2b_latency: out_tvalid=%b prod_tready=%b, required 1 0", ov[0], pr[0]);
         n_err++;
      end
      collect(0, "b2b_sum", 260);
   endtask

   task automatic test_gaps;
      vec[0] = 100; vec[1] = 200; vec[2] = -50; vec[3] = 10;
      run_neuron(0, "gaps_bias_change", 0, 4, 1, 1, 260);
   endtask

   task automatic test_relu;
      vec[0] = 100; vec[1] = 200; vec[2] = 150; vec[3] = 50;
      run_neuron(2, "relu_clamp", -1000, 4, 0, 0, 0);
      run_neuron(0, "norelu_neg", -1000, 4, 0, 0, -500);
      vec[0] = 10; vec[1] = 20; vec[2] = 30; vec[3] = 40;
      run_neuron(2, "relu_pos", 0, 4, 0, 0, 100);
   endtask

   task automatic test_shift_sat;
      for (int i = 0; i < 16; i++) vec[i] = 524287;
      run_neuron(1, "sat_pos", 0, 16, 0, 0, 32767);
      for (int i = 0; i < 16; i++) vec[i] = -524288;
      run_neuron(1, "sat_neg", 0, 16, 0, 0, -32768);
      for (int i = 0; i < 16; i++) vec[i] = 0;
      run_neuron(1, "trunc_neg", -17, 16, 0, 0, -2);
      run_neuron(1, "trunc_pos", 31, 16, 0, 0, 1);
      for (int i = 0; i < 16; i++) vec[i] = 16;
      run_neuron(1, "shift_mid", 0, 16, 1, 0, 16);
   endtask

   task automatic test_backpressure;
      bs[0] = 16'd0;
      push(0, 7, 0); push(0, 8, 0); push(0, 9, 0); push(0, 10, 0);
      pd[0] = 20'd777;
      pv[0] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_cmp++;
         if (ov[0] !== 1'b1 || od[0] !== 16'd34 || pr[0] !== 1'b0) begin
            $display("FAIL hold_cycle%0d: valid=%b data=%0d ready=%b, required 1 34 0",
                     c, ov[0], $signed(od[0]), pr[0]);
            n_err++;
         end
      end
      otr[0] = 1'b1;
      @(negedge clk);
      otr[0] = 1'b0;
      n_cmp++;
      if (ov[0] !== 1'b0 || pr[0] !== 1'b1) begin
         $display("FAIL hold_release: valid=%b ready=%b, required 0 1", ov[0], pr[0]);
         n_err++;
      end
      @(negedge clk);
      pv[0] = 1'b0;
      push(0, 1, 0); push(0, 2, 0); push(0, 3, 0);
      collect(0, "after_hold", 783);
   endtask

   task automatic test_reset_mid;
      bs[0] = 16'd0;
      push(0, 5, 0); push(0, 6, 0);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (pr[0] !== 1'b1 || ov[0] !== 1'b0 || od[0] !== 16'd0) begin
         $display("FAIL reset_mid_acc: ready=%b valid=%b data=%0d, required 1 0 0",
                  pr[0], ov[0], od[0]);
         n_err++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      vec[0] = 1; vec[1] = 1; vec[2] = 1; vec[3] = 1;
      run_neuron(0, "after_reset_acc", 0, 4, 0, 0, 4);
      push(0, 9, 0); push(0, 9, 0); push(0, 9, 0); push(0, 9, 0);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (ov[0] !== 1'b0 || od[0] !== 16'd0 || pr[0] !== 1'b1) begin
         $display("FAIL reset_mid_out: valid=%b data=%0d ready=%b, required 0 0 1",
                  ov[0], od[0], pr[0]);
         n_err++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      vec[0] = 2; vec[1] = 2; vec[2] = 2; vec[3] = 2;
      run_neuron(0, "after_reset_out", 0, 4, 0, 0, 8);
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_gaps();
      test_relu();
      test_shift_sat();
      test_backpressure();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
